game_seq_ctrl: RTL and testbench
================================

Name: game_seq_ctrl

Overview:
- Central game sequencer for the sprite/VGA game. Owns game state (title/run/hurt/over), the jump trajectory of the player sprite, the scrolling enemy position, lives, score and the sprite animation-frame select.
- Physics advances on a one-cycle `tick` strobe from the clock divider.
- Outputs feed the sprite address generators and the pixel mux; `hit` comes from the collision comparator.

Parameters:
- GROUND_Y, 200, player resting y (row of sprite top-left), 9 bits.
- LIVES, 3, lives at game start (1..3).
- ENEMY_X0, 480, enemy x at game start (10 bits).
- SPEED, 4, enemy x decrement per tick (1..15).
- HURT_TICKS, 32, invulnerability duration in ticks (1..255).
- ANIM_TICKS, 8, ticks per animation frame (1..255).

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset, synchronous, active-low.
- tick  in  1  physics strobe, one clk wide.
- jump_req  in  1  jump request pulse (keypad/PS2 decoded).
- restart  in  1  restart pulse.
- hit  in  1  player/enemy overlap, level.
- mario_y  out  9  player sprite y.
- enemy_x  out  10  enemy sprite x.
- state  out  2  0=TITLE, 1=RUN, 2=HURT, 3=OVER.
- life  out  2  remaining lives.
- overgame  out  1  high iff state==OVER (selects game-over image).
- invuln  out  1  high iff state==HURT.
- airborne  out  1  jump in progress.
- anim_sel  out  2  player frame select: 0, 1, 2.
- score  out  16  ticks survived, saturating.

Behaviour:
- Reset: all registers update only on posedge clk when rstn==0. Values:
  - state=TITLE, mario_y=GROUND_Y, enemy_x=ENEMY_X0, life=LIVES.
  - score=0, anim_sel=0, airborne=0, jump_t=0, hurt_cnt=0, anim_cnt=0, hit_q=0.
- Reset mid-jump or mid-hurt aborts everything to these values.
- Edge detection: hit_q<=hit every cycle; hit_rise = hit & ~hit_q.
- TITLE:
  - Everything frozen.
  - jump_req or restart -> RUN next cycle. On this transition: life=LIVES, score=0, enemy_x=ENEMY_X0, mario_y=GROUND_Y, airborne=0, anim_sel=0. The jump_req is consumed and does not start a jump.
- RUN:
  - On tick: score+1 (saturate at 16'hFFFF).
  - On tick: enemy_x <= (enemy_x < SPEED) ? 10'd639 : enemy_x-SPEED.
  - On tick: anim_cnt+1. When anim_cnt reaches ANIM_TICKS-1 it clears and anim_sel steps 0->1->2->0.
  - hit_rise: if life==1 -> life=0, state=OVER; else life-1, state=HURT, hurt_cnt=0.
- HURT:
  - Same tick updates as RUN (score, enemy, anim, jump).
  - hit ignored.
  - hurt_cnt increments per tick. The tick on which hurt_cnt==HURT_TICKS-1 -> RUN.
  - hit still high on return to RUN causes no damage: an edge is required.
- OVER:
  - All outputs frozen.
  - restart -> TITLE (life/score retained until leaving TITLE).
  - jump_req ignored.
- Jump, in RUN/HURT only:
  - jump_req while airborne==0 -> airborne=1, jump_t=0.
  - No motion in that cycle, even if tick coincides.
  - jump_req while airborne is ignored (no queueing).
- Jump trajectory: on each tick while airborne, mario_y += delta(jump_t), then jump_t+1. delta by jump_t:
  - 0-9: -6
  - 10-19: -4
  - 20-31: -2
  - 32-43: +2
  - 44-53: +4
  - 54-63: +6
- Jump profile properties:
  - Net displacement is 0. Apex is GROUND_Y-124, reached after jump_t 31.
  - On the tick applying jump_t==63: mario_y is forced to GROUND_Y, airborne=0, jump_t=0.
  - Jump lasts exactly 64 ticks.
- Entering OVER freezes mario_y mid-air. Airborne is cleared only by TITLE->RUN or reset.
- Simultaneous events:
  - hit_rise and tick in the same cycle: both apply.
  - jump_req and hit_rise in the same cycle: both apply. If the hit causes OVER, the jump start is discarded.
  - restart in RUN/HURT is ignored.
- All arithmetic is unsigned, at the widths of the output ports. mario_y never underflows given GROUND_Y>=124.

Test Plan:
- Reset, then jump_req pulse -> state=1, life=3, mario_y=200, score=0, enemy_x=480, airborne=0.
- In RUN, jump_req then 64 ticks:
  - mario_y=140 after tick 10, 100 after tick 20, 76 after tick 32.
  - mario_y=200 and airborne=0 after tick 64.
  - Second jump_req at tick 30 is ignored.
- hit pulse in RUN -> life=2, state=2, invuln=1.
  - Second hit pulse during HURT -> life stays 2.
  - After 32 ticks -> state=1.
  - Hit held high across that return -> no further decrement.
- Three separate hit pulses, with HURT expiring between them -> life 3->2->1->0, state=3, overgame=1.
  - Further ticks leave score/enemy_x/mario_y unchanged.
  - restart -> state=0.
- enemy_x wrap: from enemy_x=480 with SPEED=4:
  - After 120 ticks enemy_x=0.
  - Next tick enemy_x=639.
  - anim_sel sequence 0,1,2,0 at ticks 8,16,24.
- rstn low for one cycle at jump_t=40 during HURT -> next cycle state=0, mario_y=200, airborne=0, life=3.
  - Score saturation check: force score=16'hFFFE, 3 ticks -> 16'hFFFF.

Source files
------------

// File: rtl/game_seq_if.sv
// game_seq_if: control inputs and sprite/status outputs of the game sequencer.
interface game_seq_if;
  logic        tick;
  logic        jump_req;
  logic        restart;
  logic        hit;
  logic [8:0]  mario_y;
  logic [9:0]  enemy_x;
  logic [1:0]  state;
  logic [1:0]  life;
  logic        overgame;
  logic        invuln;
  logic        airborne;
  logic [1:0]  anim_sel;
  logic [15:0] score;
  modport master (
    output tick, jump_req, restart, hit,
    input  mario_y, enemy_x, state, life, overgame, invuln, airborne, anim_sel, score
  );
  modport slave (
    input  tick, jump_req, restart, hit,
    output mario_y, enemy_x, state, life, overgame, invuln, airborne, anim_sel, score
  );
endinterface

// File: rtl/game_seq_ctrl.sv
// game_seq_ctrl: game state, jump trajectory, enemy scroll, lives, score and animation.
module game_seq_ctrl #(
  parameter int GROUND_Y   = 200,
  parameter int LIVES      = 3,
  parameter int ENEMY_X0   = 480,
  parameter int SPEED      = 4,
  parameter int HURT_TICKS = 32,
  parameter int ANIM_TICKS = 8
) (
  input logic        clk,
  input logic        rstn,
  game_seq_if.slave  io
);
  typedef enum logic [1:0] {TITLE, RUN, HURT, OVER} state_t;
  state_t      st, st_n;
  logic [8:0]  y, y_n;
  logic [9:0]  ex, ex_n;
  logic [1:0]  life, life_n, anim, anim_n;
  logic [15:0] sc, sc_n;
  logic        air, air_n, hit_q, hit_rise, active, go_over, up;
  logic [5:0]  jt, jt_n;
  logic [7:0]  hc, hc_n, ac, ac_n;
  logic [2:0]  d;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      st    <= TITLE;
      y     <= 9'(GROUND_Y);
      ex    <= 10'(ENEMY_X0);
      life  <= 2'(LIVES);
      sc    <= '0;
      anim  <= '0;
      air   <= 1'b0;
      jt    <= '0;
      hc    <= '0;
      ac    <= '0;
      hit_q <= 1'b0;
    end else begin
      st    <= st_n;
      y     <= y_n;
      ex    <= ex_n;
      life  <= life_n;
      sc    <= sc_n;
      anim  <= anim_n;
      air   <= air_n;
      jt    <= jt_n;
      hc    <= hc_n;
      ac    <= ac_n;
      hit_q <= io.hit;
    end
  end
  // Jump profile is symmetric: rise 6/4/2 over 10/10/12 ticks, then mirror.
  assign up = jt < 6'd32;
  assign d  = (jt < 6'd10 || jt >= 6'd54) ? 3'd6 : (jt < 6'd20 || jt >= 6'd44) ? 3'd4 : 3'd2;
  assign hit_rise = io.hit & ~hit_q;
  assign active   = st == RUN || st == HURT;
  assign go_over  = st == RUN && hit_rise && life == 2'd1;
  always_comb begin
    st_n   = st;
    y_n    = y;
    ex_n   = ex;
    life_n = life;
    sc_n   = sc;
    anim_n = anim;
    air_n  = air;
    jt_n   = jt;
    hc_n   = hc;
    ac_n   = ac;
    if (st == TITLE && (io.jump_req || io.restart)) begin
      st_n   = RUN;
      life_n = 2'(LIVES);
      sc_n   = '0;
      ex_n   = 10'(ENEMY_X0);
      y_n    = 9'(GROUND_Y);
      air_n  = 1'b0;
      jt_n   = '0;
      anim_n = '0;
      ac_n   = '0;
      hc_n   = '0;
    end
    if (st == OVER && io.restart) st_n = TITLE;
    if (active) begin
      if (io.tick) begin
        sc_n   = sc == 16'hFFFF ? sc : sc + 16'd1;
        ex_n   = ex < 10'(SPEED) ? 10'd639 : ex - 10'(SPEED);
        ac_n   = ac == 8'(ANIM_TICKS - 1) ? 8'd0 : ac + 8'd1;
        anim_n = ac == 8'(ANIM_TICKS - 1) ? (anim == 2'd2 ? 2'd0 : anim + 2'd1) : anim;
      end
      // A jump start takes the whole cycle; a fatal hit discards it.
      if (io.jump_req && !air && !go_over) begin
        air_n = 1'b1;
        jt_n  = '0;
      end else if (io.tick && air) begin
        y_n   = jt == 6'd63 ? 9'(GROUND_Y) : up ? y - {6'd0, d} : y + {6'd0, d};
        jt_n  = jt + 6'd1;
        air_n = jt != 6'd63;
      end
      if (st == HURT && io.tick) begin
        hc_n = hc + 8'd1;
        if (hc == 8'(HURT_TICKS - 1)) st_n = RUN;
      end
      if (st == RUN && hit_rise) begin
        life_n = life - 2'd1;
        st_n   = go_over ? OVER : HURT;
        hc_n   = '0;
      end
    end
  end
  assign io.mario_y  = y;
  assign io.enemy_x  = ex;
  assign io.state    = st;
  assign io.life     = life;
  assign io.overgame = st == OVER;
  assign io.invuln   = st == HURT;
  assign io.airborne = air;
  assign io.anim_sel = anim;
  assign io.score    = sc;
endmodule

// File: tb/tb_game_seq_ctrl.sv
// tb_game_seq_ctrl: vector table with scoreboard queue plus hand-written corner sequences.
module tb_game_seq_ctrl;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  game_seq_if io ();
  game_seq_ctrl dut (.clk(clk), .rstn(rstn), .io(io));
  typedef struct {
    logic        tk, jr, rs, ht;
    int          n;
    logic [1:0]  st, lf;
    logic [8:0]  y;
    logic [9:0]  ex;
    logic        air;
    logic [15:0] sc;
  } vec_t;
  vec_t vecs[23];
  vec_t sb[$];
  int tests = 0;
  int fails = 0;
  function automatic vec_t mk(input logic tk, jr, rs, ht, input int n, input logic [1:0] st, lf,
                              input logic [8:0] y, input logic [9:0] ex, input logic air, input logic [15:0] sc);
    vec_t v;
    v.tk = tk; v.jr = jr; v.rs = rs; v.ht = ht; v.n = n;
    v.st = st; v.lf = lf; v.y = y; v.ex = ex; v.air = air; v.sc = sc;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask
  task automatic drive(input logic tk, jr, rs, ht, input int n);
    for (int k = 0; k < n; k++) begin
      io.tick = tk; io.jump_req = jr; io.restart = rs; io.hit = ht;
      @(posedge clk);
      #1;
    end
    io.tick = 1'b0; io.jump_req = 1'b0; io.restart = 1'b0; io.hit = 1'b0;
  endtask
  task automatic reset_start();
    rstn = 1'b0;
    drive(0, 0, 0, 0, 1);
    rstn = 1'b1;
    drive(0, 1, 0, 0, 1);
  endtask
  initial begin
    vec_t e;
    io.tick = 1'b0; io.jump_req = 1'b0; io.restart = 1'b0; io.hit = 1'b0;
    //               tk jr rs ht  n  st lf  y    ex  air sc
    vecs[0]  = mk(0, 0, 0, 0, 1,  0, 3, 200, 480, 0, 0);
    vecs[1]  = mk(0, 1, 0, 0, 1,  1, 3, 200, 480, 0, 0);
    vecs[2]  = mk(1, 0, 0, 0, 5,  1, 3, 200, 460, 0, 5);
    vecs[3]  = mk(0, 1, 0, 0, 1,  1, 3, 200, 460, 1, 5);
    vecs[4]  = mk(1, 0, 0, 0, 10, 1, 3, 140, 420, 1, 15);
    vecs[5]  = mk(1, 0, 0, 0, 10, 1, 3, 100, 380, 1, 25);
    vecs[6]  = mk(1, 1, 0, 0, 10, 1, 3, 80,  340, 1, 35);
    vecs[7]  = mk(1, 0, 0, 0, 2,  1, 3, 76,  332, 1, 37);
    vecs[8]  = mk(1, 0, 0, 0, 32, 1, 3, 200, 204, 0, 69);
    vecs[9]  = mk(0, 0, 0, 1, 1,  2, 2, 200, 204, 0, 69);
    vecs[10] = mk(1, 0, 0, 0, 10, 2, 2, 200, 164, 0, 79);
    vecs[11] = mk(0, 0, 0, 1, 1,  2, 2, 200, 164, 0, 79);
    vecs[12] = mk(1, 0, 0, 0, 21, 2, 2, 200, 80,  0, 100);
    vecs[13] = mk(1, 0, 0, 1, 1,  1, 2, 200, 76,  0, 101);
    vecs[14] = mk(0, 0, 0, 1, 3,  1, 2, 200, 76,  0, 101);
    vecs[15] = mk(0, 0, 0, 0, 1,  1, 2, 200, 76,  0, 101);
    vecs[16] = mk(0, 0, 0, 1, 1,  2, 1, 200, 76,  0, 101);
    vecs[17] = mk(1, 0, 0, 0, 32, 1, 1, 200, 591, 0, 133);
    vecs[18] = mk(0, 1, 0, 1, 1,  3, 0, 200, 591, 0, 133);
    vecs[19] = mk(1, 1, 0, 0, 5,  3, 0, 200, 591, 0, 133);
    vecs[20] = mk(0, 0, 1, 0, 1,  0, 0, 200, 591, 0, 133);
    vecs[21] = mk(1, 0, 0, 0, 3,  0, 0, 200, 591, 0, 133);
    vecs[22] = mk(0, 0, 1, 0, 1,  1, 3, 200, 480, 0, 0);
    drive(0, 0, 0, 0, 2);
    rstn = 1'b1;
    for (int i = 0; i < 23; i++) begin
      sb.push_back(vecs[i]);
      drive(vecs[i].tk, vecs[i].jr, vecs[i].rs, vecs[i].ht, vecs[i].n);
      e = sb.pop_front();
      chk($sformatf("v%0d state", i), 32'(io.state), 32'(e.st));
      chk($sformatf("v%0d life", i), 32'(io.life), 32'(e.lf));
      chk($sformatf("v%0d mario_y", i), 32'(io.mario_y), 32'(e.y));
      chk($sformatf("v%0d enemy_x", i), 32'(io.enemy_x), 32'(e.ex));
      chk($sformatf("v%0d airborne", i), 32'(io.airborne), 32'(e.air));
      chk($sformatf("v%0d score", i), 32'(io.score), 32'(e.sc));
      chk($sformatf("v%0d overgame", i), 32'(io.overgame), 32'(e.st == 2'd3));
      chk($sformatf("v%0d invuln", i), 32'(io.invuln), 32'(e.st == 2'd2));
    end
    // enemy wrap and animation stepping
    reset_start();
    drive(1, 0, 0, 0, 7);
    chk("anim t7", 32'(io.anim_sel), 0);
    drive(1, 0, 0, 0, 1);
    chk("anim t8", 32'(io.anim_sel), 1);
    drive(1, 0, 0, 0, 8);
    chk("anim t16", 32'(io.anim_sel), 2);
    drive(1, 0, 0, 0, 8);
    chk("anim t24", 32'(io.anim_sel), 0);
    drive(1, 0, 0, 0, 96);
    chk("enemy t120", 32'(io.enemy_x), 0);
    drive(1, 0, 0, 0, 1);
    chk("enemy t121", 32'(io.enemy_x), 639);
    // reset mid-jump during HURT
    reset_start();
    drive(0, 1, 0, 0, 1);
    chk("jump start air", 32'(io.airborne), 1);
    drive(1, 0, 0, 0, 20);
    drive(0, 0, 0, 1, 1);
    chk("jump hurt state", 32'(io.state), 2);
    drive(1, 0, 0, 0, 20);
    chk("jump t40 y", 32'(io.mario_y), 92);
    chk("jump t40 state", 32'(io.state), 2);
    rstn = 1'b0;
    drive(0, 0, 0, 0, 1);
    rstn = 1'b1;
    chk("rst state", 32'(io.state), 0);
    chk("rst y", 32'(io.mario_y), 200);
    chk("rst air", 32'(io.airborne), 0);
    chk("rst life", 32'(io.life), 3);
    chk("rst score", 32'(io.score), 0);
    // score saturation
    reset_start();
    drive(1, 0, 0, 0, 65534);
    chk("score fffe", 32'(io.score), 32'hFFFE);
    drive(1, 0, 0, 0, 3);
    chk("score sat", 32'(io.score), 32'hFFFF);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
